// File: rtl/noc_vc_queue.sv
// -----------------------------------------------------------------------------
// noc_vc_queue
// Per-virtual-channel packet queues with a single output arbiter.
// Incoming packets are steered to the VC named in their low vc field. Each VC
// has its own circular FIFO. One granted VC head is presented at the output,
// selected by round-robin or by VC0 strict priority with round-robin fallback.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous clear of all queues and the round-robin pointer
//   in_valid/in_pkt/in_ready   : input handshake (ready = target VC not full)
//   out_valid/out_pkt/out_vc/out_ready : output handshake for the granted VC
//   occupancy     : per-VC entry counts, VC0 in the LSBs
// -----------------------------------------------------------------------------
module noc_vc_queue #(
    parameter int NUM_VC   = 4,
    parameter int DEPTH    = 4,
    parameter int PKT_W    = 80,
    parameter bit PRIO_VC0 = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  in_valid,
    input  logic [PKT_W-1:0]                      in_pkt,
    output logic                                  in_ready,
    output logic                                  out_valid,
    output logic [PKT_W-1:0]                      out_pkt,
    output logic [$clog2(NUM_VC)-1:0]             out_vc,
    input  logic                                  out_ready,
    output logic [NUM_VC*$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int VCW  = $clog2(NUM_VC);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);

    logic [PKT_W-1:0] mem_q    [NUM_VC][DEPTH];
    logic [PTRW-1:0]  wr_ptr_q [NUM_VC];
    logic [PTRW-1:0]  wr_ptr_d [NUM_VC];
    logic [PTRW-1:0]  rd_ptr_q [NUM_VC];
    logic [PTRW-1:0]  rd_ptr_d [NUM_VC];
    logic [CNTW-1:0]  count_q  [NUM_VC];
    logic [CNTW-1:0]  count_d  [NUM_VC];
    logic [VCW-1:0]   rr_ptr_q;
    logic [VCW-1:0]   rr_ptr_d;

    logic [NUM_VC-1:0] not_empty;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] push_vc;
    logic [NUM_VC-1:0] pop_vc;
    logic [VCW-1:0]    tgt_vc;
    logic [VCW-1:0]    gnt_vc;
    logic [VCW-1:0]    arb_idx;
    logic              gnt_any;
    logic              gnt_prio;
    logic              push;
    logic              pop;

    // With NUM_VC=2 only vc bit 0 is used; upper vc bits are ignored.
    assign tgt_vc = in_pkt[VCW-1:0];

    always_comb begin
        not_empty = '0;
        full      = '0;
        occupancy = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            not_empty[v]                 = (count_q[v] != '0);
            full[v]                      = (count_q[v] == CNTW'(DEPTH));
            occupancy[v*CNTW +: CNTW]    = count_q[v];
        end
    end

    // Readiness looks only at the pre-edge count, never at a same-cycle pop.
    assign in_ready = !full[tgt_vc] && !flush;
    assign push     = in_valid && in_ready;

    // Arbiter: search upward from rr_ptr with natural VCW-bit wrap
    // (NUM_VC is 2 or 4). In priority mode VC0 is excluded from the search
    // and granted outright whenever it holds data.
    always_comb begin
        gnt_vc   = '0;
        gnt_any  = 1'b0;
        gnt_prio = 1'b0;
        arb_idx  = '0;
        if (PRIO_VC0 && not_empty[0]) begin
            gnt_any  = 1'b1;
            gnt_prio = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                arb_idx = rr_ptr_q + VCW'(i);
                if (!gnt_any && not_empty[arb_idx] && !(PRIO_VC0 && arb_idx == '0)) begin
                    gnt_vc  = arb_idx;
                    gnt_any = 1'b1;
                end
            end
        end
    end

    assign out_valid = gnt_any && !flush;
    assign pop       = out_valid && out_ready;
    assign out_vc    = out_valid ? gnt_vc : '0;
    assign out_pkt   = out_valid ? mem_q[gnt_vc][rd_ptr_q[gnt_vc]] : '0;

    always_comb begin
        push_vc = '0;
        pop_vc  = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            push_vc[v] = push && (tgt_vc == VCW'(v));
            pop_vc[v]  = pop && (gnt_vc == VCW'(v));
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                wr_ptr_d[v] = '0;
                rd_ptr_d[v] = '0;
                count_d[v]  = '0;
            end
            rr_ptr_d = '0;
        end else begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                // DEPTH is a power of two, so pointers wrap by overflow.
                if (push_vc[v]) wr_ptr_d[v] = wr_ptr_q[v] + PTRW'(1);
                if (pop_vc[v])  rd_ptr_d[v] = rd_ptr_q[v] + PTRW'(1);
                case ({push_vc[v], pop_vc[v]})
                    2'b10:   count_d[v] = count_q[v] + CNTW'(1);
                    2'b01:   count_d[v] = count_q[v] - CNTW'(1);
                    default: count_d[v] = count_q[v];
                endcase
            end
            // A priority grant of VC0 leaves the round-robin position alone.
            if (pop && !gnt_prio) rr_ptr_d = gnt_vc + VCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            count_q  <= '{default: '0};
            rr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Packet storage carries no reset; validity comes from the counts.
    always_ff @(posedge clk) begin
        if (push) mem_q[tgt_vc][wr_ptr_q[tgt_vc]] <= in_pkt;
    end

endmodule

// File: tb/tb_noc_vc_queue.sv
// -----------------------------------------------------------------------------
// tb_noc_vc_queue
// Drives a round-robin instance (dut_a) and a VC0-priority instance (dut_b)
// with shared stimulus. A queue-based reference model tracks each instance.
// -----------------------------------------------------------------------------
module tb_noc_vc_queue;

    typedef logic [79:0] pkt_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    pkt_t        in_pkt;
    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    pkt_t        out_pkt_a, out_pkt_b;
    logic [1:0]  out_vc_a, out_vc_b;
    logic [11:0] occ_a, occ_b;

    int checks   = 0;
    int failures = 0;

    // Model: mq[m*4+v] is the packet list of VC v in instance m (0=rr, 1=prio).
    pkt_t mq [8][$];
    int   rr [2];

    always #5 clk = ~clk;

    noc_vc_queue dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pkt(in_pkt),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_pkt(out_pkt_a),
        .out_vc(out_vc_a), .out_ready(out_ready), .occupancy(occ_a)
    );

    noc_vc_queue #(.PRIO_VC0(1'b1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pkt(in_pkt),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_pkt(out_pkt_b),
        .out_vc(out_vc_b), .out_ready(out_ready), .occupancy(occ_b)
    );

    function automatic pkt_t rand_pkt(int vc);
        logic [95:0] r;
        pkt_t p;
        r = {$urandom(), $urandom(), $urandom()};
        p = r[79:0];
        p[1:0] = 2'(vc);
        return p;
    endfunction

    function automatic int m_gnt(int m);
        int v;
        if (m == 1 && mq[4].size() != 0) return 0;
        for (int k = 0; k < 4; k++) begin
            v = (rr[m] + k) % 4;
            if (m == 1 && v == 0) continue;
            if (mq[m*4+v].size() != 0) return v;
        end
        return -1;
    endfunction

    function automatic logic m_valid(int m);
        return !flush && (m_gnt(m) >= 0);
    endfunction

    function automatic logic m_ready(int m, pkt_t p);
        return !flush && (mq[m*4 + int'(p[1:0])].size() < 4);
    endfunction

    function automatic logic [1:0] m_vc(int m);
        return m_valid(m) ? 2'(m_gnt(m)) : 2'd0;
    endfunction

    function automatic pkt_t m_pkt(int m);
        return m_valid(m) ? mq[m*4 + m_gnt(m)][0] : '0;
    endfunction

    function automatic logic [11:0] m_occ(int m);
        logic [11:0] o = '0;
        for (int v = 0; v < 4; v++) o[v*3 +: 3] = 3'(mq[m*4+v].size());
        return o;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mq[i].delete();
        rr[0] = 0;
        rr[1] = 0;
    endtask

    // One clock edge; the model consumes the inputs that were stable before it.
    task automatic step();
        int   g;
        logic rdy;
        pkt_t dropped;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst || flush) begin
                for (int v = 0; v < 4; v++) mq[m*4+v].delete();
                rr[m] = 0;
            end else begin
                g   = m_gnt(m);
                rdy = mq[m*4 + int'(in_pkt[1:0])].size() < 4;
                if (g >= 0 && out_ready) begin
                    dropped = mq[m*4+g].pop_front();
                    if (!(m == 1 && g == 0)) rr[m] = (g + 1) % 4;
                end
                if (in_valid && rdy) mq[m*4 + int'(in_pkt[1:0])].push_back(in_pkt);
            end
        end
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic push_one(int vc);
        in_pkt = rand_pkt(vc); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; step(); flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); in_pkt = rand_pkt(2);
        #1;
        checks++;
        if ({out_valid_a, out_vc_a, out_pkt_a, occ_a, in_ready_a} !== {1'b0, 2'd0, 80'd0, 12'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", {out_valid_a, out_vc_a, out_pkt_a, occ_a, in_ready_a}, {1'b0, 2'd0, 80'd0, 12'd0, 1'b1});
        end
        checks++;
        if ({out_valid_b, out_vc_b, out_pkt_b, occ_b, in_ready_b} !== {1'b0, 2'd0, 80'd0, 12'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", {out_valid_b, out_vc_b, out_pkt_b, occ_b, in_ready_b}, {1'b0, 2'd0, 80'd0, 12'd0, 1'b1});
        end
        step(); step();
        rst = 1'b0;
        model_clear();
        step();
    endtask

    task automatic test_fill_stall();
        do_flush();
        for (int i = 0; i < 4; i++) begin
            in_pkt = rand_pkt(2); in_valid = 1'b1; #1;
            checks++;
            if (in_ready_a !== 1'b1) begin failures++; $display("FAIL fill_ready got=%b exp=1", in_ready_a); end
            step();
        end
        in_pkt = rand_pkt(2); #1;
        checks++;
        if (occ_a[8:6] !== 3'd4 || occ_a !== m_occ(0)) begin
            failures++; $display("FAIL fill_occ got=%h exp=%h", occ_a, m_occ(0));
        end
        checks++;
        if (in_ready_a !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", in_ready_a); end
        step();
        in_pkt = rand_pkt(1); #1;
        checks++;
        if (in_ready_a !== 1'b1) begin failures++; $display("FAIL vc1_ready got=%b exp=1", in_ready_a); end
        step();
        in_valid = 1'b0; #1;
        checks++;
        if (occ_a !== 12'h108) begin failures++; $display("FAIL stall_occ got=%h exp=%h", occ_a, 12'h108); end
    endtask

    task automatic test_round_robin();
        do_flush();
        for (int r = 0; r < 2; r++) begin
            for (int v = 0; v < 4; v++) push_one(v);
            out_ready = 1'b1; #1;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (out_vc_a !== 2'(k) || out_pkt_a !== m_pkt(0)) begin
                    failures++;
                    $display("FAIL rr_order round=%0d got=%0d/%h exp=%0d/%h", r, out_vc_a, out_pkt_a, k, m_pkt(0));
                end
                step();
            end
            out_ready = 1'b0;
        end
    endtask

    task automatic test_prio();
        do_flush();
        push_one(1); push_one(3);
        out_ready = 1'b1; #1;
        checks++;
        if (out_vc_b !== 2'd1) begin failures++; $display("FAIL prio_first got=%0d exp=1", out_vc_b); end
        step();
        out_ready = 1'b0; in_pkt = rand_pkt(0); in_valid = 1'b1; #1;
        checks++;
        if (out_vc_b !== 2'd3) begin failures++; $display("FAIL prio_nobypass got=%0d exp=3", out_vc_b); end
        step();
        in_valid = 1'b0; out_ready = 1'b1; #1;
        checks++;
        if (out_vc_b !== 2'd0 || out_pkt_b !== m_pkt(1)) begin
            failures++; $display("FAIL prio_vc0 got=%0d/%h exp=0/%h", out_vc_b, out_pkt_b, m_pkt(1));
        end
        step();
        checks++;
        if (out_vc_b !== 2'd3 || out_pkt_b !== m_pkt(1)) begin
            failures++; $display("FAIL prio_resume got=%0d/%h exp=3/%h", out_vc_b, out_pkt_b, m_pkt(1));
        end
        step();
        checks++;
        if (out_valid_b !== 1'b0) begin failures++; $display("FAIL prio_empty got=%b exp=0", out_valid_b); end
        out_ready = 1'b0;
    endtask

    task automatic test_push_pop_full();
        do_flush();
        for (int i = 0; i < 3; i++) push_one(1);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_pkt = rand_pkt(1); #1;
            checks++;
            if (in_ready_a !== 1'b1 || out_pkt_a !== m_pkt(0)) begin
                failures++; $display("FAIL pp_head i=%0d got=%b/%h exp=1/%h", i, in_ready_a, out_pkt_a, m_pkt(0));
            end
            step();
            checks++;
            if (occ_a[5:3] !== 3'd3) begin failures++; $display("FAIL pp_count i=%0d got=%0d exp=3", i, occ_a[5:3]); end
        end
        in_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_pkt_a !== m_pkt(0)) begin failures++; $display("FAIL pp_drain got=%h exp=%h", out_pkt_a, m_pkt(0)); end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        pkt_t first;
        do_flush();
        push_one(0); push_one(0); push_one(2);
        flush = 1'b1; in_pkt = rand_pkt(1); in_valid = 1'b1; #1;
        checks++;
        if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin
            failures++; $display("FAIL flush_cycle got=%b%b exp=00", out_valid_a, in_ready_a);
        end
        step();
        flush = 1'b0; in_valid = 1'b0; #1;
        checks++;
        if (occ_a !== 12'd0 || out_valid_a !== 1'b0) begin
            failures++; $display("FAIL flush_after got=%h/%b exp=000/0", occ_a, out_valid_a);
        end
        first = rand_pkt(2); in_pkt = first; in_valid = 1'b1;
        step();
        in_pkt = rand_pkt(0); out_ready = 1'b1; #1;
        checks++;
        if (out_pkt_a !== first) begin failures++; $display("FAIL flush_first got=%h exp=%h", out_pkt_a, first); end
        step();
        idle();
    endtask

    task automatic test_reset_async();
        pkt_t p;
        do_flush();
        push_one(0); push_one(3);
        #2; rst = 1'b1; #1;
        checks++;
        if ({out_valid_a, out_vc_a, out_pkt_a, occ_a} !== 95'd0) begin
            failures++; $display("FAIL async_rst got=%h exp=0", {out_valid_a, out_vc_a, out_pkt_a, occ_a});
        end
        model_clear();
        step();
        rst = 1'b0; in_pkt = rand_pkt(3); #1;
        checks++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            failures++; $display("FAIL post_rst got=%b%b exp=10", in_ready_a, out_valid_a);
        end
        p = rand_pkt(3); in_pkt = p; in_valid = 1'b1;
        step();
        in_valid = 1'b0; #1;
        checks++;
        if (out_valid_a !== 1'b1 || out_vc_a !== 2'd3 || out_pkt_a !== p) begin
            failures++; $display("FAIL post_rst_push got=%b/%0d/%h exp=1/3/%h", out_valid_a, out_vc_a, out_pkt_a, p);
        end
        do_flush();
    endtask

    task automatic test_random();
        logic [95:0] act, exp;
        for (int c = 0; c < 400; c++) begin
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pkt    = rand_pkt($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            act = {in_ready_a, out_valid_a, out_vc_a, out_pkt_a, occ_a};
            exp = {m_ready(0, in_pkt), m_valid(0), m_vc(0), m_pkt(0), m_occ(0)};
            checks++;
            if (act !== exp) begin failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", c, act, exp); end
            act = {in_ready_b, out_valid_b, out_vc_b, out_pkt_b, occ_b};
            exp = {m_ready(1, in_pkt), m_valid(1), m_vc(1), m_pkt(1), m_occ(1)};
            checks++;
            if (act !== exp) begin failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", c, act, exp); end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_round_robin();
        test_prio();
        test_push_pop_full();
        test_flush();
        test_reset_async();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
